// File: rtl/xentry_types_pkg.sv
// Shared types for the front end: memory operation codes, fetch FSM states
// and instruction size.
package xentry_types;

    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        STORE = 2'b01
    } memory_operation_e;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_STALE
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of packed {instr, pc} entries with a single-cycle flush.
// The head entry is presented combinationally from storage.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the icache request handshake
// and buffers returned words for decode, honouring redirects.
module fetch_unit
    import xentry_types::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned     QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [XLEN-1:0]   dec_instr,
    output logic [XLEN-1:0]   dec_pc,
    output logic [XLEN-1:0]   pipe_req_address,
    output memory_operation_e pipe_req_type,
    output logic              pipe_req_valid,
    input  logic [XLEN-1:0]   pipe_fetched_word,
    input  logic              pipe_req_fulfilled
);

    localparam int unsigned     CW         = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C    = CW'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] INSTR_STEP = XLEN'(INSTR_BYTES);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] hold_addr;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   occ_next;
    logic            q_full;
    logic            q_empty;
    logic            enq;
    logic            deq;
    logic            credit;

    assign redirect_target = redirect_pc & ~XLEN'(3);

    // Words returned in the same cycle as a redirect, or while STALE, are dropped.
    assign enq      = (state == FETCH_REQ) && pipe_req_fulfilled && !redirect_valid;
    assign deq      = dec_valid && dec_ready && !redirect_valid;
    assign occ_next = q_count + CW'(enq) - CW'(deq);
    assign credit   = (occ_next < DEPTH_C);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            FETCH_IDLE: begin
                if (redirect_valid) begin
                    state_next = FETCH_REQ;
                    pc_next    = redirect_target;
                end else if (!q_full || deq) begin
                    state_next = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = pipe_req_fulfilled ? FETCH_REQ : FETCH_STALE;
                end else if (pipe_req_fulfilled) begin
                    pc_next    = pc + INSTR_STEP;
                    state_next = credit ? FETCH_REQ : FETCH_IDLE;
                end
            end
            FETCH_STALE: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (pipe_req_fulfilled) begin
                    state_next = FETCH_REQ;
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
    end

    // pc already holds the redirect target while STALE; hold_addr keeps the
    // outstanding request's address stable until icache completes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH_IDLE;
            pc        <= RESET_PC;
            hold_addr <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == FETCH_REQ && redirect_valid && !pipe_req_fulfilled) begin
                hold_addr <= pc;
            end
        end
    end

    assign pipe_req_valid   = (state != FETCH_IDLE);
    assign pipe_req_address = (state == FETCH_STALE) ? hold_addr : pc;
    assign pipe_req_type    = LOAD;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data ({pipe_fetched_word, pc}),
        .pop       (deq),
        .head_data ({dec_instr, dec_pc}),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign dec_valid = !q_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a small icache responder model.
module tb_fetch_unit;
    import xentry_types::*;

    localparam logic [31:0] K = 32'hDEAD_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [31:0]       dec_instr;
    logic [31:0]       dec_pc;
    logic [31:0]       pipe_req_address;
    memory_operation_e pipe_req_type;
    logic              pipe_req_valid;
    logic [31:0]       pipe_fetched_word;
    logic              pipe_req_fulfilled;

    logic              reset2;
    logic              redirect_valid2;
    logic [31:0]       redirect_pc2;
    logic              dec_valid2;
    logic              dec_ready2;
    logic [31:0]       dec_instr2;
    logic [31:0]       dec_pc2;
    logic [31:0]       pipe_req_address2;
    memory_operation_e pipe_req_type2;
    logic              pipe_req_valid2;
    logic [31:0]       pipe_fetched_word2;
    logic              pipe_req_fulfilled2;

    int unsigned lat;
    int unsigned cnt;
    bit          en;
    bit          en2;
    bit          ful;
    bit          ful2;
    logic [31:0] ful_addr;
    logic [31:0] ful2_addr;
    int          checks;
    int          errors;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .pipe_req_address(pipe_req_address), .pipe_req_type(pipe_req_type),
        .pipe_req_valid(pipe_req_valid), .pipe_fetched_word(pipe_fetched_word),
        .pipe_req_fulfilled(pipe_req_fulfilled)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .dec_valid(dec_valid2), .dec_ready(dec_ready2), .dec_instr(dec_instr2), .dec_pc(dec_pc2),
        .pipe_req_address(pipe_req_address2), .pipe_req_type(pipe_req_type2),
        .pipe_req_valid(pipe_req_valid2), .pipe_fetched_word(pipe_fetched_word2),
        .pipe_req_fulfilled(pipe_req_fulfilled2)
    );

    // Advance to the next falling edge and play icache: fulfil `lat` cycles
    // after a request first becomes visible, returning address ^ K.
    task automatic step();
        @(negedge clk);
        if (ful || !pipe_req_valid) cnt = 0;
        ful = 1'b0;
        if (en && pipe_req_valid) begin
            if (cnt == lat) begin
                ful      = 1'b1;
                ful_addr = pipe_req_address;
            end else begin
                cnt++;
            end
        end
        pipe_req_fulfilled = ful;
        pipe_fetched_word  = ful ? (pipe_req_address ^ K) : 32'h0;
        ful2 = en2 && pipe_req_valid2;
        if (ful2) ful2_addr = pipe_req_address2;
        pipe_req_fulfilled2 = ful2;
        pipe_fetched_word2  = pipe_req_address2 ^ K;
    endtask

    task automatic apply_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        cnt   = 0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        step();
        checks++; if (dec_valid !== 1'b0) begin $display("FAIL reset_dec_valid got %b exp 0", dec_valid); errors++; end
        checks++; if (dec_instr !== 32'h0) begin $display("FAIL reset_dec_instr got %h exp 0", dec_instr); errors++; end
        checks++; if (dec_pc !== 32'h0) begin $display("FAIL reset_dec_pc got %h exp 0", dec_pc); errors++; end
        checks++; if (pipe_req_valid !== 1'b0) begin $display("FAIL reset_req_valid got %b exp 0", pipe_req_valid); errors++; end
        checks++; if (pipe_req_address !== 32'h0) begin $display("FAIL reset_req_addr got %h exp 0", pipe_req_address); errors++; end
        checks++; if (pipe_req_type !== LOAD) begin $display("FAIL reset_req_type got %0d exp %0d", pipe_req_type, LOAD); errors++; end
        checks++; if (pipe_req_address2 !== 32'hFFFF_FFF8) begin $display("FAIL reset2_req_addr got %h exp fffffff8", pipe_req_address2); errors++; end
        checks++; if (pipe_req_valid2 !== 1'b0) begin $display("FAIL reset2_req_valid got %b exp 0", pipe_req_valid2); errors++; end
    endtask

    task automatic test_basic();
        logic [31:0] exp_addr [3];
        logic [31:0] last;
        int  k;
        bit  pending;
        exp_addr = '{32'h0, 32'h4, 32'h8};
        lat = 2; en = 1'b1; dec_ready = 1'b1;
        apply_reset();
        k = 0; pending = 1'b0; last = '0;
        for (int c = 0; c < 40 && (k < 3 || pending); c++) begin
            step();
            if (pending) begin
                checks++; if (dec_valid !== 1'b1) begin $display("FAIL basic_dec_valid got %b exp 1", dec_valid); errors++; end
                checks++; if (dec_pc !== last) begin $display("FAIL basic_dec_pc got %h exp %h", dec_pc, last); errors++; end
                checks++; if (dec_instr !== (last ^ K)) begin $display("FAIL basic_dec_instr got %h exp %h", dec_instr, last ^ K); errors++; end
                pending = 1'b0;
            end
            if (ful && k < 3) begin
                checks++; if (ful_addr !== exp_addr[k]) begin $display("FAIL basic_req_addr got %h exp %h", ful_addr, exp_addr[k]); errors++; end
                checks++; if (pipe_req_type !== LOAD) begin $display("FAIL basic_req_type got %0d exp %0d", pipe_req_type, LOAD); errors++; end
                last = exp_addr[k];
                pending = 1'b1;
                k++;
            end
        end
        checks++; if (k != 3) begin $display("FAIL basic_timeout got %0d fulfils exp 3", k); errors++; end
    endtask

    task automatic test_full();
        int n;
        lat = 0; en = 1'b1; dec_ready = 1'b0;
        apply_reset();
        n = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (ful) n++;
        end
        checks++; if (n != 4) begin $display("FAIL full_count got %0d exp 4", n); errors++; end
        checks++; if (pipe_req_valid !== 1'b0) begin $display("FAIL full_req_valid got %b exp 0", pipe_req_valid); errors++; end
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin $display("FAIL full_head got %b/%h exp 1/0", dec_valid, dec_pc); errors++; end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        checks++; if (pipe_req_valid !== 1'b1) begin $display("FAIL credit_req_valid got %b exp 1", pipe_req_valid); errors++; end
        checks++; if (pipe_req_address !== 32'h10) begin $display("FAIL credit_req_addr got %h exp 10", pipe_req_address); errors++; end
        checks++; if (dec_pc !== 32'h4) begin $display("FAIL credit_head got %h exp 4", dec_pc); errors++; end
        step();
        checks++; if (pipe_req_valid !== 1'b0) begin $display("FAIL refull_req_valid got %b exp 0", pipe_req_valid); errors++; end
    endtask

    task automatic test_redirect_stale();
        int  n;
        bit  moved;
        bit  saw8;
        bit  done;
        lat = 5; en = 1'b1; dec_ready = 1'b1;
        apply_reset();
        n = 0;
        while (!(pipe_req_valid && pipe_req_address == 32'h8) && n < 40) begin step(); n++; end
        checks++; if (!(pipe_req_valid && pipe_req_address == 32'h8)) begin $display("FAIL stale_wait8 got %h exp 8", pipe_req_address); errors++; end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin $display("FAIL stale_flush got %b exp 0", dec_valid); errors++; end
        moved = 1'b0; saw8 = 1'b0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (dec_valid && dec_pc == 32'h8) saw8 = 1'b1;
            if (!ful && (pipe_req_address != 32'h8 || !pipe_req_valid)) moved = 1'b1;
            if (ful) begin
                checks++; if (ful_addr !== 32'h8) begin $display("FAIL stale_ful_addr got %h exp 8", ful_addr); errors++; end
                done = 1'b1;
            end
            step();
        end
        checks++; if (!done || moved) begin $display("FAIL stale_hold got done=%b moved=%b exp 1/0", done, moved); errors++; end
        checks++; if (pipe_req_valid !== 1'b1 || pipe_req_address !== 32'h100) begin $display("FAIL stale_next_req got %b/%h exp 1/100", pipe_req_valid, pipe_req_address); errors++; end
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (dec_valid && dec_pc == 32'h8) saw8 = 1'b1;
            if (ful) done = 1'b1;
            step();
        end
        checks++; if (!done || dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_instr !== (32'h100 ^ K)) begin
            $display("FAIL stale_dec got %b %h %h exp 1 100 %h", dec_valid, dec_pc, dec_instr, 32'h100 ^ K); errors++; end
        checks++; if (saw8) begin $display("FAIL stale_discard got word 8 at decode exp never"); errors++; end
    endtask

    task automatic test_redirect_fulfil();
        int n;
        lat = 0; en = 1'b1; dec_ready = 1'b1;
        apply_reset();
        n = 0;
        while (!(ful && ful_addr == 32'h8) && n < 20) begin step(); n++; end
        checks++; if (!(ful && ful_addr == 32'h8) || dec_valid !== 1'b1 || dec_pc !== 32'h4) begin
            $display("FAIL rf_setup got ful=%b addr=%h head=%h exp 1 8 4", ful, ful_addr, dec_pc); errors++; end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
        step();
        redirect_valid = 1'b0;
        checks++; if (dec_valid !== 1'b0) begin $display("FAIL rf_flush got %b exp 0", dec_valid); errors++; end
        checks++; if (pipe_req_valid !== 1'b1 || pipe_req_address !== 32'h200) begin $display("FAIL rf_req got %b/%h exp 1/200", pipe_req_valid, pipe_req_address); errors++; end
        step();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200 || dec_instr !== (32'h200 ^ K)) begin
            $display("FAIL rf_dec0 got %b %h %h exp 1 200 %h", dec_valid, dec_pc, dec_instr, 32'h200 ^ K); errors++; end
        step();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h204) begin $display("FAIL rf_dec1 got %b %h exp 1 204", dec_valid, dec_pc); errors++; end
        dec_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [3];
        int k;
        exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        en2 = 1'b1; dec_ready2 = 1'b1;
        reset2 = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            step();
            if (ful2) begin
                checks++; if (ful2_addr !== exp_addr[k]) begin $display("FAIL wrap_addr got %h exp %h", ful2_addr, exp_addr[k]); errors++; end
                k++;
            end
        end
        step();
        checks++; if (k != 3 || dec_valid2 !== 1'b1 || dec_pc2 !== 32'h0 || dec_instr2 !== K) begin
            $display("FAIL wrap_dec got k=%0d %b %h %h exp 3 1 0 %h", k, dec_valid2, dec_pc2, dec_instr2, K); errors++; end
        en2 = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        lat = 3; en = 1'b1; dec_ready = 1'b0;
        apply_reset();
        n = 0;
        while (!ful && n < 20) begin step(); n++; end
        step();
        checks++; if (dec_valid !== 1'b1 || pipe_req_valid !== 1'b1 || pipe_req_address !== 32'h4) begin
            $display("FAIL ar_setup got %b %b %h exp 1 1 4", dec_valid, pipe_req_valid, pipe_req_address); errors++; end
        #2 reset = 1'b0;
        #1;
        checks++; if (pipe_req_valid !== 1'b0 || pipe_req_address !== 32'h0) begin
            $display("FAIL ar_req got %b/%h exp 0/0", pipe_req_valid, pipe_req_address); errors++; end
        checks++; if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
            $display("FAIL ar_dec got %b %h %h exp 0 0 0", dec_valid, dec_pc, dec_instr); errors++; end
        step();
        step();
        cnt = 0;
        reset = 1'b1;
        step();
        checks++; if (pipe_req_valid !== 1'b1 || pipe_req_address !== 32'h0) begin
            $display("FAIL ar_restart got %b/%h exp 1/0", pipe_req_valid, pipe_req_address); errors++; end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; reset2 = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        redirect_valid2 = 1'b0; redirect_pc2 = '0;
        dec_ready = 1'b0; dec_ready2 = 1'b0;
        pipe_req_fulfilled = 1'b0; pipe_fetched_word = '0;
        pipe_req_fulfilled2 = 1'b0; pipe_fetched_word2 = '0;
        lat = 0; cnt = 0; en = 1'b0; en2 = 1'b0; ful = 1'b0; ful2 = 1'b0;
        ful_addr = '0; ful2_addr = '0;

        test_reset();
        test_basic();
        test_full();
        test_redirect_stale();
        test_redirect_fulfil();
        test_wrap();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
